// File: rtl/frame_pattern_monitor.sv
// ---------------------------------------------------------------------------
// frame_pattern_monitor
//   Serialises each WIDTH-bit din word MSB-first (one bit per enabled cycle)
//   and compares the last WIDTH bits against PATTERN under a don't-care mask.
//   Frame-aligned mode compares once per frame (last slot); sliding mode
//   compares on every enabled cycle once the history holds WIDTH-1 bits.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : sample enable; all state holds when low
//   clr        : synchronous clear of slot, history, fill, sticky and count
//   mode       : 0 = frame-aligned, 1 = sliding; sampled at enabled slot 0
//   din        : input word, bit din[WIDTH-1-slot] consumed in slot `slot`
//   mask       : 1 = don't-care at that pattern position
//   err        : one-cycle pulse, registered, one cycle after a match
//   err_sticky : set by any match, cleared by rst/clr
//   err_cnt    : saturating match count
//   slot       : current bit slot 0..WIDTH-1
// ---------------------------------------------------------------------------
module frame_pattern_monitor #(
    parameter int unsigned       WIDTH   = 3,
    parameter logic [WIDTH-1:0]  PATTERN = {WIDTH{1'b1}},
    parameter int unsigned       CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          din,
    input  logic [WIDTH-1:0]          mask,
    output logic                      err,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [$clog2(WIDTH)-1:0]  slot
);

    localparam int unsigned         SLOT_W    = $clog2(WIDTH);
    localparam int unsigned         FILL_W    = $clog2(WIDTH + 1);
    localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0]   FILL_DONE = FILL_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_ALIGN = 2'b00,
        S_FILL  = 2'b01,
        S_SLIDE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_eff;
    state_t              w_state_nxt;
    logic                r_mode_q;
    logic [SLOT_W-1:0]   r_slot;
    // Only the low WIDTH-1 history bits ever reach the candidate word, so the
    // top bit of the architectural history is not stored.
    logic [WIDTH-2:0]    r_hist;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic                r_err;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_slot0;
    logic                w_sbit;
    logic                w_mode_eff;
    logic [WIDTH-1:0]    w_cand;
    logic                w_cmp;
    logic                w_match;

    assign w_slot0    = (r_slot == '0);
    assign w_sbit     = din[LAST_SLOT - r_slot];
    assign w_cand     = {r_hist, w_sbit};
    // mode is only honoured at an enabled slot 0; elsewhere the latched copy rules
    assign w_mode_eff = (en && w_slot0) ? mode : r_mode_q;

    // Transitions taken at slot 0 already govern that cycle's compare and
    // fill counting, so the slot-0 bit is the first bit counted in S_FILL.
    always_comb begin
        w_state_eff = S_ALIGN;
        case (r_state)
            S_ALIGN: w_state_eff = (en && w_slot0 && mode) ? S_FILL : S_ALIGN;
            S_FILL:  w_state_eff = w_mode_eff ? S_FILL  : S_ALIGN;
            S_SLIDE: w_state_eff = w_mode_eff ? S_SLIDE : S_ALIGN;
            default: w_state_eff = S_ALIGN;
        endcase
    end

    always_comb begin
        w_state_nxt = w_state_eff;
        w_fill_nxt  = r_fill;
        if (en && (w_state_eff == S_FILL)) begin
            w_fill_nxt = ((r_state == S_FILL) ? r_fill : '0) + FILL_W'(1);
            if (w_fill_nxt >= FILL_DONE) begin
                w_state_nxt = S_SLIDE;
            end
        end
    end

    assign w_cmp   = en && (((w_state_eff == S_ALIGN) && (r_slot == LAST_SLOT)) ||
                            (w_state_eff == S_SLIDE));
    assign w_match = w_cmp && (((w_cand ^ PATTERN) & ~mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ALIGN;
        end else if (clr) begin
            r_state <= S_ALIGN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= 1'b0;
            r_slot   <= '0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_mode_q <= 1'b0;
            r_slot   <= '0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_err  <= w_match;
            r_fill <= w_fill_nxt;
            if (w_match) begin
                r_sticky <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (en) begin
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SLOT_W'(1);
                r_hist <= w_cand[WIDTH-2:0];
                if (w_slot0) begin
                    r_mode_q <= mode;
                end
            end
        end
    end

    assign err        = r_err;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_cnt;
    assign slot       = r_slot;

endmodule

// File: tb/tb_frame_pattern_monitor.sv
// ---------------------------------------------------------------------------
// tb_frame_pattern_monitor
//   Directed, table-driven bench for frame_pattern_monitor with WIDTH=3,
//   PATTERN=3'b111, CNT_W=4. Inputs change on the falling edge; outputs are
//   sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_frame_pattern_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] din = '0;
    logic [2:0] mask = '0;
    logic       err;
    logic       err_sticky;
    logic [3:0] err_cnt;
    logic [1:0] slot;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    frame_pattern_monitor #(
        .WIDTH   (3),
        .PATTERN (3'b111),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .mode       (mode),
        .din        (din),
        .mask       (mask),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .slot       (slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       mode;
        logic [2:0] din;
        logic [2:0] mask;
        logic       e_err;
        logic       e_sticky;
        logic [3:0] e_cnt;
        logic [1:0] e_slot;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic v_en, input logic v_clr, input logic v_mode,
                       input logic [2:0] v_din, input logic [2:0] v_mask,
                       input logic x_err, input logic x_sticky,
                       input logic [3:0] x_cnt, input logic [1:0] x_slot);
        vec_t v;
        v.en = v_en; v.clr = v_clr; v.mode = v_mode; v.din = v_din; v.mask = v_mask;
        v.e_err = x_err; v.e_sticky = x_sticky; v.e_cnt = x_cnt; v.e_slot = x_slot;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, settle past the rising edge.
    task automatic step(input logic v_en, input logic v_clr, input logic v_mode,
                        input logic [2:0] v_din, input logic [2:0] v_mask);
        @(negedge clk);
        en = v_en; clr = v_clr; mode = v_mode; din = v_din; mask = v_mask;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   en clr mode din     mask    err st cnt slot
        // aligned match
        add(1, 0, 0, 3'b111, 3'b000, 0, 0, 0, 1);
        add(1, 0, 0, 3'b111, 3'b000, 0, 0, 0, 2);
        add(1, 0, 0, 3'b111, 3'b000, 1, 1, 1, 0);
        // aligned no-match
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 1, 1);
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 1, 2);
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 1, 0);
        // masked LSB turns 110 into a match
        add(1, 0, 0, 3'b110, 3'b001, 0, 1, 1, 1);
        add(1, 0, 0, 3'b110, 3'b001, 0, 1, 1, 2);
        add(1, 0, 0, 3'b110, 3'b001, 1, 1, 2, 0);
        // enable gating 1,0,1,0,1
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 2, 1);
        add(0, 0, 0, 3'b111, 3'b000, 0, 1, 2, 1);
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 2, 2);
        add(0, 0, 0, 3'b111, 3'b000, 0, 1, 2, 2);
        add(1, 0, 0, 3'b111, 3'b000, 1, 1, 3, 0);
        // sliding: stream 1,1,1,1,1,0 -> matches on bits 3,4,5
        add(1, 0, 1, 3'b111, 3'b000, 0, 1, 3, 1);
        add(1, 0, 1, 3'b111, 3'b000, 0, 1, 3, 2);
        add(1, 0, 1, 3'b111, 3'b000, 1, 1, 4, 0);
        add(1, 0, 1, 3'b110, 3'b000, 1, 1, 5, 1);
        add(1, 0, 1, 3'b110, 3'b000, 1, 1, 6, 2);
        add(1, 0, 1, 3'b110, 3'b000, 0, 1, 6, 0);
        // same stream aligned: only the frame boundary compares
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 6, 1);
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 6, 2);
        add(1, 0, 0, 3'b111, 3'b000, 1, 1, 7, 0);
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 7, 1);
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 7, 2);
        add(1, 0, 0, 3'b110, 3'b000, 0, 1, 7, 0);
        // clr coincident with a match wins
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 7, 1);
        add(1, 0, 0, 3'b111, 3'b000, 0, 1, 7, 2);
        add(1, 1, 0, 3'b111, 3'b000, 0, 0, 0, 0);
        // mode raised mid-frame is ignored until slot 0
        add(1, 0, 0, 3'b111, 3'b000, 0, 0, 0, 1);
        add(1, 0, 1, 3'b111, 3'b000, 0, 0, 0, 2);
        add(1, 0, 1, 3'b111, 3'b000, 1, 1, 1, 0);

        // reset state
        #12;
        chk("reset_err",    32'(err),        32'd0);
        chk("reset_sticky", 32'(err_sticky), 32'd0);
        chk("reset_cnt",    32'(err_cnt),    32'd0);
        chk("reset_slot",   32'(slot),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            step(tv[i].en, tv[i].clr, tv[i].mode, tv[i].din, tv[i].mask);
            chk($sformatf("v%0d_err", i),    32'(err),        32'(tv[i].e_err));
            chk($sformatf("v%0d_sticky", i), 32'(err_sticky), 32'(tv[i].e_sticky));
            chk($sformatf("v%0d_cnt", i),    32'(err_cnt),    32'(tv[i].e_cnt));
            chk($sformatf("v%0d_slot", i),   32'(slot),       32'(tv[i].e_slot));
        end

        // saturation: 20 aligned matches starting from a count of 1
        for (int f = 0; f < 20; f++) begin
            step(1, 0, 0, 3'b111, 3'b000);
            chk($sformatf("sat%0d_slot0_err", f), 32'(err), 32'd0);
            step(1, 0, 0, 3'b111, 3'b000);
            step(1, 0, 0, 3'b111, 3'b000);
            chk($sformatf("sat%0d_err", f), 32'(err), 32'd1);
            chk($sformatf("sat%0d_cnt", f), 32'(err_cnt), (f + 2 > 15) ? 32'd15 : 32'(f + 2));
        end
        step(1, 0, 0, 3'b000, 3'b000);
        chk("sat_hold_cnt",    32'(err_cnt),    32'd15);
        chk("sat_hold_sticky", 32'(err_sticky), 32'd1);
        chk("sat_hold_err",    32'(err),        32'd0);
        step(1, 0, 0, 3'b000, 3'b000);
        step(1, 0, 0, 3'b000, 3'b000);

        // asynchronous reset between edges at slot 1
        step(1, 0, 0, 3'b111, 3'b000);
        chk("arst_pre_slot", 32'(slot), 32'd1);
        #3;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("arst_sticky", 32'(err_sticky), 32'd0);
        chk("arst_cnt",    32'(err_cnt),    32'd0);
        chk("arst_slot",   32'(slot),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 3'b111, 3'b000);
        chk("post_rst_b1_err", 32'(err), 32'd0);
        step(1, 0, 0, 3'b111, 3'b000);
        chk("post_rst_b2_err", 32'(err), 32'd0);
        step(1, 0, 0, 3'b111, 3'b000);
        chk("post_rst_b3_err", 32'(err), 32'd1);
        chk("post_rst_cnt",    32'(err_cnt), 32'd1);

        // clr in the same cycle as a match
        step(1, 0, 0, 3'b111, 3'b000);
        step(1, 0, 0, 3'b111, 3'b000);
        step(1, 1, 0, 3'b111, 3'b000);
        chk("clr_match_err",    32'(err),        32'd0);
        chk("clr_match_sticky", 32'(err_sticky), 32'd0);
        chk("clr_match_cnt",    32'(err_cnt),    32'd0);
        chk("clr_match_slot",   32'(slot),       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
